tick_gen_prescaler: RTL and testbench
=====================================

Name: tick_gen_prescaler

Overview:
- Programmable prescaler that produces the single-cycle `enable` strobe consumed by the team's modulo-n counters. It divides the system clock by a runtime-loadable ratio.
- Supports free-running and one-shot modes.
- Also provides a square-wave divided clock (data signal, not a clock net) for LED/debug use, and a wrapping count of emitted ticks.
- Sits between the board clock and every counter/display block that needs a slow time base.

Parameters:
- W, 26, width of divisor and internal phase counter.
- DEFAULT_DIV, 50_000_000, divisor loaded at reset; must be 1..2^W-1.
- TC_W, 16, width of tick_count output.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- start  in  1  level-sampled each cycle; 1 = begin/restart generation.
- stop  in  1  1 = halt generation, return to IDLE.
- oneshot  in  1  sampled with start; 1 = emit exactly one tick then stop.
- div_load  in  1  1 = capture div_value this cycle.
- div_value  in  W  new divide ratio N (tick period = N clk cycles).
- tick  out  1  one-cycle high strobe, once per N cycles while running.
- slow_clk  out  1  toggles on every tick; period 2N cycles.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse when a one-shot completes.
- div_err  out  1  one-cycle pulse when div_load is rejected (div_value==0).
- tick_count  out  TC_W  ticks emitted since last start, wraps 2^TC_W-1 -> 0.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; phase=0; div_active=div_shadow=DEFAULT_DIV; shadow_pend=0.
  - Outputs: tick=0, slow_clk=0, running=0, done=0, div_err=0, tick_count=0.
  - Mid-run reset aborts immediately; no tick or done is emitted.
- States:
  - IDLE: phase held at 0.
    - start=1 & stop=0 -> RUN; mode latched from oneshot; phase=0; tick_count=0.
  - RUN: phase increments each cycle.
    - When phase==div_active-1: tick=1 next cycle (registered), phase->0, slow_clk toggles, tick_count+1.
    - If mode=oneshot, on that terminal count -> IDLE with done=1 in the same cycle tick=1.
    - stop=1 -> IDLE next cycle, phase=0, no tick; slow_clk holds its level.
    - start=1 (stop=0) while in RUN -> restart: phase=0, tick_count=0, mode re-latched, no tick this cycle.
- Latency: first tick asserts exactly N cycles after the cycle start is sampled high. Subsequent ticks are every N cycles.
- N=1: tick high every cycle while running; slow_clk toggles every cycle.
- start & stop in the same cycle: stop wins (IDLE, or stays IDLE).
- Divisor load:
  - div_value==0: ignored, div_err=1 for one cycle, registers unchanged.
  - IDLE: div_active<=div_value next cycle.
  - RUN: div_shadow<=div_value, shadow_pend=1. At the next terminal count div_active<=div_shadow and shadow_pend=0. The current period completes with the old N, so there is no glitch and no short period.
  - Multiple loads in one period: last one wins.
  - div_load coincident with start from IDLE: new value is used for the first period.
- Arithmetic: phase is W bits unsigned; compare is equality to div_active-1; no overflow possible since div_active>=1.
- tick, done and div_err are registered single-cycle pulses; they are never asserted for 2 consecutive cycles except tick when N=1.

Test Plan:
- Reset then div_load=1, div_value=4, start=1 pulse, oneshot=0 -> tick high at cycles 4, 8, 12 after start; slow_clk 0->1->0->1; tick_count 1, 2, 3.
- N=3, oneshot=1, start -> single tick at cycle 3 with done=1 the same cycle; running falls; no further ticks over 20 cycles; tick_count=1.
- N=5 running, div_load value 2 at cycle 2 of a period -> that period still ends at 5; following ticks every 2 cycles.
- div_load with div_value=0 -> div_err pulse 1 cycle; tick spacing unchanged; start+stop together in IDLE -> stays IDLE, no tick.
- N=1 run -> tick continuously high, slow_clk toggles every cycle; stop -> tick low next cycle, running=0.
- N=6 running, drive reset low mid-period (async, between edges) -> all outputs 0 immediately; after release, DEFAULT_DIV restored and state is IDLE until start.

Source files
------------

// File: rtl/tick_gen_prescaler.sv
// ----------------------------------------------------------------------------
// tick_gen_prescaler
//
// Divides the system clock by a runtime-loadable ratio N and emits a
// single-cycle `tick` strobe once every N cycles while running. The strobe is
// the time base for the modulo-n counters and display blocks downstream.
// Free-running and one-shot modes are supported. A square-wave `slow_clk`
// (a data signal, never used as a clock net) and a wrapping count of emitted
// ticks are provided for LED/debug use.
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   reset       asynchronous, active-low reset
//   start       1 = begin generation (from IDLE) or restart it (in RUN)
//   stop        1 = halt generation and return to IDLE; wins over start
//   oneshot     sampled together with start; 1 = one tick, then IDLE
//   div_load    1 = capture div_value this cycle
//   div_value   new divide ratio N (tick period = N cycles); 0 is rejected
//   tick        registered one-cycle strobe, once per N cycles while running
//   slow_clk    toggles on every tick (period 2N cycles)
//   running     high while in the RUN state
//   done        one-cycle pulse, coincident with the tick ending a one-shot
//   div_err     one-cycle pulse when a div_load carried div_value == 0
//   tick_count  ticks emitted since the last start, wraps to 0
// ----------------------------------------------------------------------------
module tick_gen_prescaler #(
   parameter int W           = 26,
   parameter int DEFAULT_DIV = 50_000_000,
   parameter int TC_W        = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stop,
   input  logic            oneshot,
   input  logic            div_load,
   input  logic [W-1:0]    div_value,
   output logic            tick,
   output logic            slow_clk,
   output logic            running,
   output logic            done,
   output logic            div_err,
   output logic [TC_W-1:0] tick_count
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

   state_e            state_q,       state_d;
   logic [W-1:0]      phase_q,       phase_d;
   logic [W-1:0]      div_active_q,  div_active_d;
   logic [W-1:0]      div_shadow_q,  div_shadow_d;
   logic              shadow_pend_q, shadow_pend_d;
   logic              mode_os_q,     mode_os_d;
   logic              tick_q,        tick_d;
   logic              done_q,        done_d;
   logic              div_err_q,     div_err_d;
   logic              slow_clk_q,    slow_clk_d;
   logic [TC_W-1:0]   tick_count_q,  tick_count_d;

   logic              load_ok;
   logic              terminal;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      div_active_d  = div_active_q;
      div_shadow_d  = div_shadow_q;
      shadow_pend_d = shadow_pend_q;
      mode_os_d     = mode_os_q;
      tick_d        = 1'b0;
      done_d        = 1'b0;
      slow_clk_d    = slow_clk_q;
      tick_count_d  = tick_count_q;
      terminal      = 1'b0;

      load_ok       = div_load && (div_value != '0);
      div_err_d     = div_load && (div_value == '0);

      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (start && !stop) begin
               state_d      = RUN;
               mode_os_d    = oneshot;
               tick_count_d = '0;
            end
         end
         RUN: begin
            if (stop) begin
               // slow_clk deliberately keeps its level across a stop.
               state_d = IDLE;
               phase_d = '0;
            end else if (start) begin
               // Restart: the period begins afresh, no tick this cycle.
               phase_d      = '0;
               tick_count_d = '0;
               mode_os_d    = oneshot;
            end else if (phase_q == div_active_q - W'(1)) begin
               terminal     = 1'b1;
               phase_d      = '0;
               tick_d       = 1'b1;
               slow_clk_d   = ~slow_clk_q;
               tick_count_d = tick_count_q + TC_W'(1);
               if (mode_os_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               phase_d = phase_q + W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A ratio loaded while running waits in the shadow register and takes
      // effect only at a period boundary, so no period is ever cut short.
      // One left pending by a stop is applied as soon as we are idle.
      if (terminal || (state_q == IDLE)) begin
         if (shadow_pend_q) begin
            div_active_d = div_shadow_q;
         end
         shadow_pend_d = 1'b0;
      end

      if (load_ok) begin
         if (state_q == IDLE) begin
            div_active_d  = div_value;
            shadow_pend_d = 1'b0;
         end else begin
            div_shadow_d  = div_value;
            shadow_pend_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   // All flops, including the divisor registers, are reset: a mid-run reset
   // must abort cleanly and restore the default ratio.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         phase_q       <= '0;
         div_active_q  <= DIV_RST;
         div_shadow_q  <= DIV_RST;
         shadow_pend_q <= 1'b0;
         mode_os_q     <= 1'b0;
         tick_q        <= 1'b0;
         done_q        <= 1'b0;
         div_err_q     <= 1'b0;
         slow_clk_q    <= 1'b0;
         tick_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         div_active_q  <= div_active_d;
         div_shadow_q  <= div_shadow_d;
         shadow_pend_q <= shadow_pend_d;
         mode_os_q     <= mode_os_d;
         tick_q        <= tick_d;
         done_q        <= done_d;
         div_err_q     <= div_err_d;
         slow_clk_q    <= slow_clk_d;
         tick_count_q  <= tick_count_d;
      end
   end

   assign tick       = tick_q;
   assign done       = done_q;
   assign div_err    = div_err_q;
   assign slow_clk   = slow_clk_q;
   assign tick_count = tick_count_q;
   assign running    = (state_q == RUN);

endmodule

// File: tb/tb_tick_gen_prescaler.sv
// ----------------------------------------------------------------------------
// tb_tick_gen_prescaler
//
// Bench for tick_gen_prescaler, built with a small default ratio and a narrow
// tick counter so default restore and counter wrap are cheap to reach.
// Each scenario pushes the ticks it expects (cycle, count, slow_clk level,
// done) into a scoreboard queue when it drives start; the per-cycle monitor
// pops and compares whenever the DUT raises tick.
// ----------------------------------------------------------------------------
module tb_tick_gen_prescaler;

   localparam int W           = 8;
   localparam int DEFAULT_DIV = 7;
   localparam int TC_W        = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            stop;
   logic            oneshot;
   logic            div_load;
   logic [W-1:0]    div_value;
   logic            tick;
   logic            slow_clk;
   logic            running;
   logic            done;
   logic            div_err;
   logic [TC_W-1:0] tick_count;

   tick_gen_prescaler #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .TC_W        (TC_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .oneshot    (oneshot),
      .div_load   (div_load),
      .div_value  (div_value),
      .tick       (tick),
      .slow_clk   (slow_clk),
      .running    (running),
      .done       (done),
      .div_err    (div_err),
      .tick_count (tick_count)
   );

   always #5 clk = ~clk;

   // Rising-edge index; read only #1 after an edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              at;
      logic [TC_W-1:0] cnt;
      logic            slow;
      logic            dn;
   } exp_t;

   exp_t            sb[$];
   logic            exp_slow;
   logic [TC_W-1:0] exp_cnt;
   int              n_vec = 0;
   int              n_err = 0;

   // Schedule one expected tick; slow_clk and count advance per tick.
   task automatic push_tick(input int at, input logic dn);
      exp_t e;
      exp_slow = ~exp_slow;
      exp_cnt  = exp_cnt + 1'b1;
      e.at   = at;
      e.cnt  = exp_cnt;
      e.slow = exp_slow;
      e.dn   = dn;
      sb.push_back(e);
   endtask

   // Advance one cycle, then compare the DUT against the scoreboard head.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (tick) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_tick: tick=1 at cycle %0d, required no tick", cyc);
         end else begin
            e = sb.pop_front();
            if (cyc !== e.at || tick_count !== e.cnt || slow_clk !== e.slow || done !== e.dn) begin
               n_err++;
               $display("FAIL tick_event: cycle=%0d cnt=%0d slow=%0b done=%0b, required cycle=%0d cnt=%0d slow=%0b done=%0b",
                        cyc, tick_count, slow_clk, done, e.at, e.cnt, e.slow, e.dn);
            end
         end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
         n_vec++;
         n_err++;
         e = sb.pop_front();
         $display("FAIL missing_tick: tick=0 at cycle %0d, required tick at cycle %0d", cyc, e.at);
      end
      if (done && !tick) begin
         n_vec++;
         n_err++;
         $display("FAIL done_without_tick: done=1 tick=0 at cycle %0d, required done only with tick", cyc);
      end
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      oneshot   = 1'b0;
      div_load  = 1'b0;
      div_value = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      exp_slow = 1'b0;
      exp_cnt  = '0;
      step();
   endtask

   // Load ratio n together with start from IDLE; returns the start edge.
   task automatic launch(input int n, input logic os, output int s);
      div_load  = 1'b1;
      div_value = W'(n);
      start     = 1'b1;
      oneshot   = os;
      step();
      s        = cyc;
      div_load = 1'b0;
      start    = 1'b0;
      oneshot  = 1'b0;
      exp_cnt  = '0;
   endtask

   task automatic halt();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({tick, slow_clk, running, done, div_err, tick_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got tick=%0b slow=%0b run=%0b done=%0b err=%0b cnt=%0d, required all 0",
                  tick, slow_clk, running, done, div_err, tick_count);
      end
   endtask

   task automatic test_free_run();
      int s;
      do_reset();
      launch(4, 1'b0, s);
      n_vec++;
      if (running !== 1'b1) begin
         n_err++;
         $display("FAIL free_running: running=%0b, required 1", running);
      end
      push_tick(s + 4, 1'b0);
      push_tick(s + 8, 1'b0);
      push_tick(s + 12, 1'b0);
      run_to(s + 13);
      halt();
      run_to(s + 20);
      n_vec++;
      if (running !== 1'b0 || slow_clk !== 1'b1 || tick_count !== 4'd3 || sb.size() != 0) begin
         n_err++;
         $display("FAIL free_stop: run=%0b slow=%0b cnt=%0d pending=%0d, required run=0 slow=1 cnt=3 pending=0",
                  running, slow_clk, tick_count, sb.size());
      end
   endtask

   task automatic test_oneshot();
      int s;
      do_reset();
      launch(3, 1'b1, s);
      push_tick(s + 3, 1'b1);
      run_to(s + 3);
      n_vec++;
      if (running !== 1'b0 || done !== 1'b1) begin
         n_err++;
         $display("FAIL oneshot_end: run=%0b done=%0b, required run=0 done=1", running, done);
      end
      run_to(s + 23);
      n_vec++;
      if (tick_count !== 4'd1 || done !== 1'b0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL oneshot_after: cnt=%0d done=%0b pending=%0d, required cnt=1 done=0 pending=0",
                  tick_count, done, sb.size());
      end
   endtask

   task automatic test_shadow_load();
      int s;
      do_reset();
      launch(5, 1'b0, s);
      push_tick(s + 5, 1'b0);
      push_tick(s + 10, 1'b0);
      push_tick(s + 12, 1'b0);
      push_tick(s + 14, 1'b0);
      run_to(s + 6);
      div_load  = 1'b1;
      div_value = W'(2);
      step();
      div_load = 1'b0;
      run_to(s + 15);
      halt();
      run_to(s + 22);
      n_vec++;
      if (sb.size() != 0 || running !== 1'b0 || tick_count !== 4'd4) begin
         n_err++;
         $display("FAIL shadow_load: pending=%0d run=%0b cnt=%0d, required pending=0 run=0 cnt=4",
                  sb.size(), running, tick_count);
      end
   endtask

   task automatic test_div_err_and_start_stop();
      int s;
      do_reset();
      launch(4, 1'b0, s);
      push_tick(s + 4, 1'b0);
      push_tick(s + 8, 1'b0);
      push_tick(s + 12, 1'b0);
      run_to(s + 5);
      div_load  = 1'b1;
      div_value = '0;
      step();
      div_load = 1'b0;
      n_vec++;
      if (div_err !== 1'b1) begin
         n_err++;
         $display("FAIL div_err_pulse: div_err=%0b, required 1", div_err);
      end
      step();
      n_vec++;
      if (div_err !== 1'b0) begin
         n_err++;
         $display("FAIL div_err_width: div_err=%0b, required 0", div_err);
      end
      run_to(s + 13);
      halt();
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      n_vec++;
      if (running !== 1'b0) begin
         n_err++;
         $display("FAIL start_stop_idle: running=%0b, required 0", running);
      end
      repeat (10) step();
      n_vec++;
      if (tick_count !== 4'd3 || sb.size() != 0) begin
         n_err++;
         $display("FAIL err_spacing: cnt=%0d pending=%0d, required cnt=3 pending=0", tick_count, sb.size());
      end
   endtask

   task automatic test_n1_wrap();
      int s;
      do_reset();
      launch(1, 1'b0, s);
      for (int k = 1; k <= 18; k++) push_tick(s + k, 1'b0);
      run_to(s + 18);
      halt();
      n_vec++;
      if (tick !== 1'b0 || running !== 1'b0 || tick_count !== 4'd2) begin
         n_err++;
         $display("FAIL n1_stop: tick=%0b run=%0b cnt=%0d, required tick=0 run=0 cnt=2",
                  tick, running, tick_count);
      end
      repeat (3) step();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL n1_pending: pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_async_reset();
      int s;
      int s2;
      do_reset();
      launch(6, 1'b0, s);
      push_tick(s + 6, 1'b0);
      run_to(s + 8);
      #2;
      reset = 1'b0;
      #1;
      n_vec++;
      if ({tick, slow_clk, running, done, div_err, tick_count} !== '0) begin
         n_err++;
         $display("FAIL async_reset: tick=%0b slow=%0b run=%0b done=%0b err=%0b cnt=%0d, required all 0",
                  tick, slow_clk, running, done, div_err, tick_count);
      end
      step();
      reset = 1'b1;
      repeat (10) step();
      n_vec++;
      if (running !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: running=%0b, required 0", running);
      end
      start = 1'b1;
      step();
      s2       = cyc;
      start    = 1'b0;
      exp_slow = 1'b0;
      exp_cnt  = '0;
      push_tick(s2 + DEFAULT_DIV, 1'b0);
      push_tick(s2 + 2 * DEFAULT_DIV, 1'b0);
      run_to(s2 + 2 * DEFAULT_DIV + 1);
      halt();
      n_vec++;
      if (sb.size() != 0 || tick_count !== 4'd2) begin
         n_err++;
         $display("FAIL default_div: pending=%0d cnt=%0d, required pending=0 cnt=2", sb.size(), tick_count);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_oneshot();
      test_shadow_load();
      test_div_err_and_start_stop();
      test_n1_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
